// File: rtl/com_uart_trans_ctrl.sv
// UART transmit controller: pops bytes from the TX FIFO and serialises them as start/data/parity/stop frames.
// Bit edges follow rising edges of baudrate_clk; fifo_rd_en and frame_done are same-cycle decodes of the FSM.
module com_uart_trans_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int BIT_CNT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baudrate_clk,
  input  logic                  FIFO_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_in,
  output logic                  fifo_rd_en,
  input  logic [1:0]            parity_mode,
  input  logic                  stop_bit_2,
  output logic                  TX,
  output logic                  ctrl_idle_state,
  output logic                  ctrl_stop_state,
  output logic                  frame_done
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] LOAD       = 3'd1;
  localparam logic [2:0] WAIT_START = 3'd2;
  localparam logic [2:0] START      = 3'd3;
  localparam logic [2:0] DATA       = 3'd4;
  localparam logic [2:0] PARITY     = 3'd5;
  localparam logic [2:0] STOP       = 3'd6;

  localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

  logic [2:0]               state;
  logic [2:0]               next_state;
  logic                     baud_q;
  logic                     baud_tick;
  logic [DATA_WIDTH-1:0]    shift_data;
  logic [BIT_CNT_WIDTH-1:0] bit_cnt;
  logic                     stop_cnt;
  logic                     par_bit;
  logic                     par_en;
  logic                     stop2_q;
  logic                     stop_last;

  assign baud_tick = baudrate_clk & ~baud_q;
  // The final stop tick is the one that is not the first of a two-stop-bit pair.
  assign stop_last = (state == STOP) && baud_tick && !(stop2_q && !stop_cnt);

  always_comb begin
    fifo_rd_en = 1'b0;
    frame_done = 1'b0;
    if (!rst) begin
      frame_done = stop_last;
      fifo_rd_en = !FIFO_empty && ((state == IDLE) || stop_last);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (!FIFO_empty) next_state = LOAD;
      LOAD:       next_state = baud_tick ? START : WAIT_START;
      WAIT_START: if (baud_tick) next_state = START;
      START:      if (baud_tick) next_state = DATA;
      DATA:       if (baud_tick && (bit_cnt == LAST_BIT)) next_state = par_en ? PARITY : STOP;
      PARITY:     if (baud_tick) next_state = STOP;
      STOP:       if (stop_last) next_state = FIFO_empty ? IDLE : LOAD;
      default:    next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      TX              <= 1'b1;
      ctrl_idle_state <= 1'b1;
      ctrl_stop_state <= 1'b0;
      baud_q          <= 1'b0;
      bit_cnt         <= '0;
      stop_cnt        <= 1'b0;
      shift_data      <= '0;
      par_bit         <= 1'b0;
      par_en          <= 1'b0;
      stop2_q         <= 1'b0;
    end else begin
      baud_q          <= baudrate_clk;
      state           <= next_state;
      ctrl_idle_state <= (next_state == IDLE);
      ctrl_stop_state <= (next_state == STOP);
      case (state)
        IDLE: TX <= 1'b1;
        LOAD: begin
          shift_data <= fifo_data_in;
          par_en     <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
          par_bit    <= (parity_mode == 2'b01) ? ~^fifo_data_in : ^fifo_data_in;
          stop2_q    <= stop_bit_2;
          if (baud_tick) TX <= 1'b0;
        end
        WAIT_START: if (baud_tick) TX <= 1'b0;
        START: begin
          if (baud_tick) begin
            TX         <= shift_data[0];
            shift_data <= shift_data >> 1;
            bit_cnt    <= '0;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_cnt == LAST_BIT) begin
              TX       <= par_en ? par_bit : 1'b1;
              stop_cnt <= 1'b0;
            end else begin
              // shift_data[0] already holds the bit after the one just sent
              bit_cnt    <= bit_cnt + BIT_CNT_WIDTH'(1);
              TX         <= shift_data[0];
              shift_data <= shift_data >> 1;
            end
          end
        end
        PARITY: begin
          if (baud_tick) begin
            TX       <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end
        STOP: if (baud_tick && stop2_q && !stop_cnt) stop_cnt <= 1'b1;
        default: TX <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_com_uart_trans_ctrl.sv
// Bench for com_uart_trans_ctrl: a queue-based FIFO and a frame-level line monitor check every transmitted frame.
module tb_com_uart_trans_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baudrate_clk = 1'b0;
  logic       FIFO_empty = 1'b1;
  logic [7:0] fifo_data_in = 8'h00;
  logic       fifo_rd_en;
  logic [1:0] parity_mode = 2'b00;
  logic       stop_bit_2 = 1'b0;
  logic       TX;
  logic       ctrl_idle_state;
  logic       ctrl_stop_state;
  logic       frame_done;

  always #5 clk = ~clk;

  com_uart_trans_ctrl #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .baudrate_clk(baudrate_clk), .FIFO_empty(FIFO_empty),
    .fifo_data_in(fifo_data_in), .fifo_rd_en(fifo_rd_en), .parity_mode(parity_mode),
    .stop_bit_2(stop_bit_2), .TX(TX), .ctrl_idle_state(ctrl_idle_state),
    .ctrl_stop_state(ctrl_stop_state), .frame_done(frame_done)
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] pm;
    logic       s2;
  } frame_t;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_q[$];
  frame_t     exp_q[$];
  int  P = 16;
  int  bcnt = 0;
  bit  pop_req = 0;
  bit  load_pending = 0;
  bit  mon_en = 0;
  bit  active = 0;
  bit  btb = 0;
  frame_t cur_f;
  logic fbits [0:11];
  int  nbits = 0, nstop = 0, cyc = 0;
  int  cycle_no = 0, last_done_cyc = -1000;
  int  pops = 0, frames_done = 0, bytes_in = 0, aborted = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle_no);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    bytes_in++;
  endtask

  // Frame as it should appear on the line: start, LSB-first data, optional parity, stop bit(s).
  task automatic start_frame(input frame_t f);
    int  k;
    bit  pe;
    cur_f = f;
    pe = (f.pm == 2'b01) || (f.pm == 2'b10);
    fbits[0] = 1'b0;
    for (int i = 0; i < 8; i++) fbits[1+i] = f.data[i];
    k = 9;
    if (pe) begin
      fbits[k] = (f.pm == 2'b10) ? ^f.data : ~^f.data;
      k++;
    end
    nstop = f.s2 ? 2 : 1;
    for (int i = 0; i < nstop; i++) fbits[k+i] = 1'b1;
    nbits = k + nstop;
    cyc = 0;
    active = 1;
  endtask

  task automatic monitor();
    check("rd_en_while_empty", fifo_rd_en & FIFO_empty, 0);
    if (!active) begin
      check("done_outside_frame", frame_done, 0);
      check("stop_state_outside_frame", ctrl_stop_state, 0);
      if (TX === 1'b0) begin
        check("start_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          start_frame(exp_q.pop_front());
          if (btb) check("b2b_gap", cycle_no - last_done_cyc, P + 1);
          btb = 0;
        end
      end else if (exp_q.size() != 0) begin
        check("idle_between_load_and_start", ctrl_idle_state, 0);
      end else if (!load_pending && fifo_q.size() == 0) begin
        check("idle_when_quiet", ctrl_idle_state, 1);
      end
    end
    if (active) begin
      check("idle_in_frame", ctrl_idle_state, 0);
      check("stop_state", ctrl_stop_state, cyc >= (nbits - nstop) * P);
      if (cyc % P == P / 2) check($sformatf("bit%0d_of_%02h", cyc / P, cur_f.data), TX, fbits[cyc / P]);
      if (cyc == nbits * P - 1) begin
        check("frame_done_at_end", frame_done, 1);
        if (frame_done === 1'b1) frames_done++;
        active = 0;
        last_done_cyc = cycle_no;
      end else begin
        check("frame_done_early", frame_done, 0);
      end
      cyc++;
    end
  endtask

  task automatic step();
    frame_t f;
    #1;
    pop_req = (fifo_rd_en === 1'b1);
    if (rst) begin
      active = 0;
      exp_q.delete();
      load_pending = 0;
      btb = 0;
    end else if (load_pending) begin
      f.data = fifo_data_in;
      f.pm   = parity_mode;
      f.s2   = stop_bit_2;
      exp_q.push_back(f);
      load_pending = 0;
    end
    if (pop_req) begin
      load_pending = 1;
      pops++;
      if (cycle_no == last_done_cyc) btb = 1;
    end
    @(posedge clk);
    #1;
    bcnt = (bcnt + 1) % P;
    baudrate_clk = (bcnt < P / 2);
    if (pop_req && fifo_q.size() > 0) fifo_data_in = fifo_q.pop_front();
    FIFO_empty = (fifo_q.size() == 0);
    @(negedge clk);
    cycle_no++;
    if (mon_en) monitor();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (n < budget && !(fifo_q.size() == 0 && exp_q.size() == 0 && !load_pending &&
                           !active && ctrl_idle_state === 1'b1)) begin
      step();
      n++;
    end
    check("drain_timeout", n < budget, 1);
  endtask

  task automatic wait_pos(input logic [7:0] b, input int pos);
    int n;
    n = 0;
    while (n < 4000 && !(active && cur_f.data == b && cyc == pos)) begin
      step();
      n++;
    end
    check($sformatf("reach_pos_%02h", b), n < 4000, 1);
  endtask

  initial begin
    int p0, f0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("rst_tx", TX, 1);
    check("rst_idle", ctrl_idle_state, 1);
    check("rst_stop", ctrl_stop_state, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    mon_en = 1;
    repeat (20) step();

    // single 0xA5 frame, no parity, one stop bit
    p0 = pops; f0 = frames_done;
    push(8'hA5);
    drain(1000);
    check("a5_pops", pops - p0, 1);
    check("a5_frames", frames_done - f0, 1);
    check("a5_idle_after", ctrl_idle_state, 1);

    // even then odd parity on 0x03
    parity_mode = 2'b10; push(8'h03); drain(1000);
    parity_mode = 2'b01; push(8'h03); drain(1000);
    parity_mode = 2'b00;

    // back-to-back frames
    p0 = pops;
    push(8'h55); push(8'hFF);
    drain(2000);
    check("b2b_pops", pops - p0, 2);

    // two stop bits
    stop_bit_2 = 1'b1; push(8'h00); drain(1000);
    stop_bit_2 = 1'b0;

    // reset during data bit 3 of 0xC3, then 0x81 follows
    f0 = frames_done;
    push(8'hC3); push(8'h81);
    wait_pos(8'hC3, 4 * P + 4);
    rst = 1'b1;
    step();
    check("midrst_tx", TX, 1);
    check("midrst_idle", ctrl_idle_state, 1);
    check("midrst_done", frame_done, 0);
    rst = 1'b0;
    aborted++;
    drain(2000);
    check("midrst_frames", frames_done - f0, 1);

    // parity change mid-frame only affects the next frame
    parity_mode = 2'b10;
    push(8'h07); push(8'h3C);
    wait_pos(8'h07, 3 * P + 4);
    parity_mode = 2'b00;
    drain(3000);

    // randomized traffic at two baud periods
    for (int sec = 0; sec < 2; sec++) begin
      P = (sec == 0) ? 16 : 10;
      bcnt = 0;
      repeat (P) step();
      for (int c = 0; c < 6000; c++) begin
        if ($urandom_range(0, 99) < 2 && fifo_q.size() < 4) push(8'($urandom_range(0, 255)));
        if ($urandom_range(0, 99) < 3) parity_mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 99) < 3) stop_bit_2 = 1'($urandom_range(0, 1));
        step();
      end
      drain(4000);
    end

    check("total_pops", pops, bytes_in);
    check("total_frames", frames_done, bytes_in - aborted);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/com_uart_trans_ctrl.md
Name: com_uart_trans_ctrl

Overview:
UART transmit controller. It pops bytes from the TX FIFO and serialises each one onto the TX line as a frame: start bit, LSB-first data, optional parity, then 1 or 2 stop bits. Bit timing comes from the baudrate_clk square wave produced by com_uart_trans_timer. The block drives ctrl_idle_state and ctrl_stop_state back into that timer, which uses them for its enable and stop-bit handling.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (5..9).
BIT_CNT_WIDTH, $clog2(DATA_WIDTH), width of the data-bit index counter.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
baudrate_clk  input  1  bit-rate square wave from the timer; each rising edge is a bit boundary
FIFO_empty  input  1  TX FIFO empty flag
fifo_data_in  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en
fifo_rd_en  output  1  one-cycle pop request
parity_mode  input  2  00/11 none, 01 odd, 10 even; sampled at frame load
stop_bit_2  input  1  0 = 1 stop bit, 1 = 2 stop bits; sampled at frame load
TX  output  1  serial line, idle high, registered
ctrl_idle_state  output  1  high while in IDLE
ctrl_stop_state  output  1  high while in STOP
frame_done  output  1  one-cycle pulse at the end of the last stop bit

Behaviour:
- Reset is synchronous and active-high: all state is cleared on a clk edge with rst=1. Reset values: TX=1, fifo_rd_en=0, ctrl_idle_state=1, ctrl_stop_state=0, frame_done=0, state=IDLE, counters=0, baud_q=0.
- Tick detection:
  - baud_q is a register holding the previous baudrate_clk.
  - baud_tick = baudrate_clk & ~baud_q.
  - All bit transitions happen only on clk edges where baud_tick=1.
- States: IDLE, LOAD, WAIT_START, START, DATA, PARITY, STOP.
- IDLE:
  - TX=1.
  - If FIFO_empty=0: fifo_rd_en=1 for one cycle, next state LOAD.
  - fifo_rd_en is never asserted while FIFO_empty=1.
- LOAD (exactly 1 cycle):
  - Latch fifo_data_in into shift_data.
  - Latch parity_mode and stop_bit_2.
  - Compute par_bit: odd = ~^data, even = ^data.
  - If baud_tick=1 in this cycle: TX<=0, go to START. Otherwise go to WAIT_START.
- WAIT_START: on tick, TX<=0, go to START.
- START: on tick, TX<=data[0], bit_cnt<=0, go to DATA.
- DATA: on tick:
  - If bit_cnt==DATA_WIDTH-1:
    - Parity enabled: TX<=par_bit, go to PARITY.
    - Parity disabled: TX<=1, stop_cnt<=0, go to STOP.
  - Otherwise: bit_cnt++, TX<=data[bit_cnt+1].
- PARITY: on tick, TX<=1, stop_cnt<=0, go to STOP.
- STOP: on tick:
  - If latched stop_bit_2=1 and stop_cnt==0: stop_cnt<=1, stay in STOP, TX stays 1.
  - Otherwise: frame_done=1 for this cycle, then:
    - If FIFO_empty=0: fifo_rd_en=1, go to LOAD (back-to-back frame; the next start bit begins on the following tick).
    - Else: go to IDLE.
- Every bit period is exactly one baud_tick interval. Only the first start bit after IDLE may be shortened or delayed by timer start-up alignment.
- ctrl_idle_state = (state==IDLE) and ctrl_stop_state = (state==STOP). Both are registered decodes of state and change in the same cycle as the state.
- Changes to parity_mode or stop_bit_2 mid-frame have no effect until the next LOAD.
- baudrate_clk held static: the FSM waits indefinitely in its current state, with TX held.
- rst mid-frame: TX=1 at the next edge, state IDLE, no frame_done pulse, no FIFO pop, and the in-flight byte is discarded.
- FIFO_empty deasserting in the same cycle as the final stop tick is honoured: pop and go to LOAD.

Test Plan:
1. Bench drives baudrate_clk with a 16-clk period. FIFO holds 0xA5; parity 00; stop_bit_2=0 -> TX bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 clk long. Exactly one fifo_rd_en pulse and one frame_done pulse. ctrl_idle_state returns to 1 afterwards.
2. Byte 0x03 with parity_mode=10 -> parity bit 0. Same byte with parity_mode=01 -> parity bit 1. Frame is 11 bits long.
3. FIFO holds 0x55 then 0xFF -> two rd_en pulses. Start bit of 0xFF follows the stop bit of 0x55 with no idle bit. ctrl_idle_state stays 0 between the frames.
4. stop_bit_2=1, byte 0x00 -> TX high for 32 clk after the last data bit. ctrl_stop_state is high for 2 bit periods. frame_done fires at the end of the second stop bit.
5. rst pulsed for 1 cycle during data bit 3 of 0xC3 -> TX=1 and ctrl_idle_state=1 next cycle, no frame_done. The next queued byte 0x81 is then transmitted correctly.
6. parity_mode switched from 10 to 00 during data bit 2 of 0x07 -> current frame still carries parity bit 1; the next frame carries no parity bit.
